// File: rtl/program_counter.sv
// Fetch-stage program counter: IDLE/RUN/HALTED sequencer with relative jumps and sticky halt.
// Optional build macro PC_OVERFLOW_TRAP_EN: halt instead of wrapping on address overflow.
module program_counter #(
    parameter int unsigned         PC_WIDTH     = 16,
    parameter int unsigned         OFFSET_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int unsigned         STEP         = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt,
    input  logic                    jump,
    input  logic [OFFSET_WIDTH-1:0] jump_value,
    output logic [PC_WIDTH-1:0]     PC
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StHalted = 2'b10
    } state_e;

`ifdef PC_OVERFLOW_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam logic [PC_WIDTH:0] StepExt = (PC_WIDTH + 1)'(STEP);

    state_e state;

    logic [PC_WIDTH:0] inc_sum;
    logic [PC_WIDTH:0] jump_sum;
    logic [PC_WIDTH:0] offset_ext;

    // Sums carry one extra bit; bit PC_WIDTH set means the result left the address space
    // (carry past the top, or a negative offset borrowing below zero).
    always_comb begin
        offset_ext = {{(PC_WIDTH + 1 - OFFSET_WIDTH){jump_value[OFFSET_WIDTH-1]}}, jump_value};
        inc_sum    = {1'b0, PC} + StepExt;
        jump_sum   = {1'b0, PC} + offset_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= StIdle;
            PC    <= RESET_PC;
        end else begin
            unique case (state)
                StIdle: begin
                    PC <= RESET_PC;
                    if (start) state <= StRun;
                end
                StRun: begin
                    if (halt) begin
                        state <= StHalted;
                    end else if (jump) begin
                        if (TrapEn && jump_sum[PC_WIDTH]) state <= StHalted;
                        else                              PC    <= jump_sum[PC_WIDTH-1:0];
                    end else begin
                        if (TrapEn && inc_sum[PC_WIDTH]) state <= StHalted;
                        else                             PC    <= inc_sum[PC_WIDTH-1:0];
                    end
                end
                StHalted: begin
                    if (start && !halt) state <= StRun;
                end
                default: begin
                    state <= StIdle;
                    PC    <= RESET_PC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Directed vector bench for program_counter: table of per-edge stimulus plus reset/wrap sequences.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halt;
    logic        jump;
    logic [7:0]  jump_value;
    logic [15:0] PC;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        halt;
        logic        jump;
        logic [7:0]  jv;
        logic [15:0] exp_pc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    program_counter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halt      (halt),
        .jump      (jump),
        .jump_value(jump_value),
        .PC        (PC)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] exp_pc);
        checks++;
        if (PC !== exp_pc) begin
            errors++;
            $display("FAIL %s: PC=%h expected %h", name, PC, exp_pc);
        end
    endtask

    // Drive inputs for one rising edge, then compare just after it.
    task automatic step(input logic s, input logic h, input logic j, input logic [7:0] jv,
                        input logic [15:0] exp_pc, input string name);
        start      = s;
        halt       = h;
        jump       = j;
        jump_value = jv;
        @(posedge clk);
        #1;
        check(name, exp_pc);
    endtask

    task automatic add(input logic s, input logic h, input logic j, input logic [7:0] jv,
                       input logic [15:0] exp_pc, input string name);
        vec_t v;
        v.start  = s;
        v.halt   = h;
        v.jump   = j;
        v.jv     = jv;
        v.exp_pc = exp_pc;
        v.name   = name;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) add(0, 0, 0, 8'h00, 16'h0000, "idle_hold");
        add(0, 1, 1, 8'h05, 16'h0000, "idle_ignores_halt_jump");
        add(1, 0, 0, 8'h00, 16'h0000, "start_edge_no_step");
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 8'h00, 16'(i), "run_increment");
        add(0, 0, 1, 8'h08, 16'h000F, "jump_plus8");
        add(0, 0, 0, 8'h00, 16'h0010, "inc_after_jump");
        add(0, 0, 1, 8'hFC, 16'h000C, "jump_minus4");
        add(0, 0, 1, 8'h08, 16'h0014, "jump_to_14");
        add(0, 1, 1, 8'h03, 16'h0014, "halt_beats_jump");
        add(0, 0, 0, 8'h00, 16'h0014, "halted_hold_a");
        add(0, 0, 0, 8'h00, 16'h0014, "halted_hold_b");
        add(0, 0, 1, 8'h05, 16'h0014, "halted_ignores_jump");
        add(1, 1, 0, 8'h00, 16'h0014, "start_with_halt_stays");
        add(1, 0, 0, 8'h00, 16'h0014, "resume_edge_no_step");
        add(0, 0, 0, 8'h00, 16'h0015, "resume_increment");
        add(0, 0, 1, 8'h00, 16'h0015, "self_jump");
        add(1, 0, 0, 8'h00, 16'h0016, "start_ignored_in_run");
        add(0, 0, 1, 8'h0D, 16'h0023, "jump_to_23");

        reset      = 1'b1;
        start      = 1'b0;
        halt       = 1'b0;
        jump       = 1'b0;
        jump_value = 8'h00;
        #1;
        check("async_reset_value", 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i].start, vecs[i].halt, vecs[i].jump, vecs[i].jv,
                               vecs[i].exp_pc, vecs[i].name);

        // Asynchronous reset between edges while running at 0x0023.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_run_immediate", 16'h0000);
        step(1, 0, 1, 8'h10, 16'h0000, "reset_wins_over_start");
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 8'h00, 16'h0000, "post_reset_idle_a");
        step(0, 0, 0, 8'h00, 16'h0000, "post_reset_idle_b");
        step(1, 0, 0, 8'h00, 16'h0000, "restart_edge");
        step(0, 0, 0, 8'h00, 16'h0001, "restart_inc_1");
        step(0, 0, 0, 8'h00, 16'h0002, "restart_inc_2");

`ifdef PC_OVERFLOW_TRAP_EN
        step(0, 0, 1, 8'hFC, 16'h0002, "trap_neg_jump_holds");
        step(0, 0, 0, 8'h00, 16'h0002, "trap_halted_hold");
        step(1, 0, 0, 8'h00, 16'h0002, "trap_resume_edge");
        step(0, 0, 1, 8'hFE, 16'h0000, "jump_to_zero");
        step(0, 0, 1, 8'hFF, 16'h0000, "trap_minus1_holds");
        step(0, 0, 0, 8'h00, 16'h0000, "trap_halted_hold_2");
`else
        step(0, 0, 1, 8'hFC, 16'hFFFE, "wrap_neg_jump");
        step(0, 0, 0, 8'h00, 16'hFFFF, "inc_to_ffff");
        step(0, 0, 0, 8'h00, 16'h0000, "wrap_ffff_to_0");
        step(0, 0, 0, 8'h00, 16'h0001, "inc_after_wrap");
        step(0, 0, 1, 8'h7F, 16'h0080, "jump_max_pos");
        step(0, 0, 1, 8'h80, 16'h0000, "jump_max_neg");
`endif

        // Reset out of HALTED.
        step(0, 1, 0, 8'h00, PC, "halt_before_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_halted", 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 8'h00, 16'h0000, "start_after_halt_reset");
        step(0, 0, 0, 8'h00, 16'h0001, "inc_after_halt_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
